// File: rtl/rf_port_arbiter.sv
// Shares the register file's single read port between decode and the debug host, with write-back bypass.
// Grant is combinational, read data lands one cycle later; a starved debug request wins after STARVE_MAX waits.
module rf_port_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic              dec_gnt,
  output logic              dec_rvalid,
  output logic [DATA_W-1:0] dec_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_rdreg,
  input  logic [DATA_W-1:0] rf_rdt,
  output logic              stall
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX must be within 1..15");
  end

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        r_cnt;
  logic              r_dec_rvalid;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_dec_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_force;
  logic              w_dec_gnt;
  logic              w_dbg_gnt;
  logic [ADDR_W-1:0] w_rdreg;
  logic [DATA_W-1:0] w_rd_dat;

  // Grants are gated by rst so nothing is offered to the pipeline while reset is held.
  assign w_force   = dbg_req && (r_cnt == STARVE_LIM);
  assign w_dbg_gnt = rst && dbg_req && (w_force || !dec_req);
  assign w_dec_gnt = rst && dec_req && !w_force;

  always_comb begin
    w_rdreg = '0;
    if (w_dec_gnt) begin
      w_rdreg = dec_addr;
    end else if (w_dbg_gnt) begin
      w_rdreg = dbg_addr;
    end
  end

  // A write-back to the address being read this cycle is newer than the file contents.
  assign w_rd_dat = (wb_en && (wb_addr == w_rdreg)) ? wb_data : rf_rdt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_dec_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_dec_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      if (w_dbg_gnt || !dbg_req) begin
        r_cnt <= '0;
      end else if (r_cnt < STARVE_LIM) begin
        r_cnt <= r_cnt + 4'd1;
      end
      r_dec_rvalid <= w_dec_gnt;
      r_dbg_rvalid <= w_dbg_gnt;
      if (w_dec_gnt) begin
        r_dec_rdata <= w_rd_dat;
      end
      if (w_dbg_gnt) begin
        r_dbg_rdata <= w_rd_dat;
      end
    end
  end

  assign dec_gnt    = w_dec_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign rf_rdreg   = w_rdreg;
  assign stall      = rst && dec_req && !w_dec_gnt;
  assign dec_rvalid = r_dec_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dec_rdata  = r_dec_rdata;
  assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter: grants, starvation override, bypass, reset behaviour.
module tb_rf_port_arbiter;

  logic       clk;
  logic       rst;
  logic       dec_req;
  logic [2:0] dec_addr;
  logic       dec_gnt;
  logic       dec_rvalid;
  logic [7:0] dec_rdata;
  logic       dbg_req;
  logic [2:0] dbg_addr;
  logic       dbg_gnt;
  logic       dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [2:0] rf_rdreg;
  logic [7:0] rf_rdt;
  logic       stall;

  logic [7:0] rf_mem [8];
  int n_chk;
  int n_pass;

  rf_port_arbiter #(.DATA_W(8), .ADDR_W(3), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .dec_req(dec_req), .dec_addr(dec_addr), .dec_gnt(dec_gnt),
    .dec_rvalid(dec_rvalid), .dec_rdata(dec_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_rdreg(rf_rdreg), .rf_rdt(rf_rdt), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behaves as a combinational read of a fixed table.
  always_comb rf_rdt = rf_mem[rf_rdreg];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; dec_req = 1'b1; dec_addr = 3'd2; dbg_req = 1'b1; dbg_addr = 3'd5;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
    tick(); tick();
    n_chk++; if (dec_gnt !== 1'b0) $display("FAIL rst_dec_gnt got=%b exp=0", dec_gnt); else n_pass++;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL rst_dbg_gnt got=%b exp=0", dbg_gnt); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall); else n_pass++;
    n_chk++; if (rf_rdreg !== 3'd0) $display("FAIL rst_rdreg got=%0d exp=0", rf_rdreg); else n_pass++;
    n_chk++; if (dec_rvalid !== 1'b0) $display("FAIL rst_dec_rvalid got=%b exp=0", dec_rvalid); else n_pass++;
    n_chk++; if (dbg_rvalid !== 1'b0) $display("FAIL rst_dbg_rvalid got=%b exp=0", dbg_rvalid); else n_pass++;
    n_chk++; if (dec_rdata !== 8'h00) $display("FAIL rst_dec_rdata got=%h exp=00", dec_rdata); else n_pass++;
    n_chk++; if (dbg_rdata !== 8'h00) $display("FAIL rst_dbg_rdata got=%h exp=00", dbg_rdata); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (dec_gnt !== 1'b1) $display("FAIL first_gnt got=%b exp=1", dec_gnt); else n_pass++;
    n_chk++; if (rf_rdreg !== 3'd2) $display("FAIL first_rdreg got=%0d exp=2", rf_rdreg); else n_pass++;
    dec_req = 1'b0; dbg_req = 1'b0;
    tick();
    n_chk++; if (dec_rvalid !== 1'b0) $display("FAIL dropped_rvalid got=%b exp=0", dec_rvalid); else n_pass++;
  endtask

  task automatic test_dec_read();
    dec_req = 1'b1; dec_addr = 3'd2;
    #1;
    n_chk++; if (dec_gnt !== 1'b1) $display("FAIL dec_gnt got=%b exp=1", dec_gnt); else n_pass++;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL dec_dbg_gnt got=%b exp=0", dbg_gnt); else n_pass++;
    n_chk++; if (rf_rdreg !== 3'd2) $display("FAIL dec_rdreg got=%0d exp=2", rf_rdreg); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL dec_stall got=%b exp=0", stall); else n_pass++;
    tick();
    dec_req = 1'b0;
    n_chk++; if (dec_rvalid !== 1'b1) $display("FAIL dec_rvalid got=%b exp=1", dec_rvalid); else n_pass++;
    n_chk++; if (dec_rdata !== 8'h5A) $display("FAIL dec_rdata got=%h exp=5a", dec_rdata); else n_pass++;
    tick();
    n_chk++; if (dec_rvalid !== 1'b0) $display("FAIL dec_rvalid_pulse got=%b exp=0", dec_rvalid); else n_pass++;
    n_chk++; if (dec_rdata !== 8'h5A) $display("FAIL dec_rdata_hold got=%h exp=5a", dec_rdata); else n_pass++;
  endtask

  task automatic test_bypass();
    dbg_req = 1'b1; dbg_addr = 3'd5; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h33;
    #1;
    n_chk++; if (dbg_gnt !== 1'b1) $display("FAIL byp_dbg_gnt got=%b exp=1", dbg_gnt); else n_pass++;
    n_chk++; if (rf_rdreg !== 3'd5) $display("FAIL byp_rdreg got=%0d exp=5", rf_rdreg); else n_pass++;
    tick();
    dbg_req = 1'b0; wb_en = 1'b0;
    n_chk++; if (dbg_rvalid !== 1'b1) $display("FAIL byp_rvalid got=%b exp=1", dbg_rvalid); else n_pass++;
    n_chk++; if (dbg_rdata !== 8'h33) $display("FAIL byp_rdata got=%h exp=33", dbg_rdata); else n_pass++;
    n_chk++; if (dec_rvalid !== 1'b0) $display("FAIL byp_dec_rvalid got=%b exp=0", dec_rvalid); else n_pass++;
  endtask

  task automatic test_no_bypass();
    dbg_req = 1'b1; dbg_addr = 3'd5; wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h33;
    tick();
    dbg_req = 1'b0; wb_en = 1'b0;
    n_chk++; if (dbg_rvalid !== 1'b1) $display("FAIL nobyp_rvalid got=%b exp=1", dbg_rvalid); else n_pass++;
    n_chk++; if (dbg_rdata !== 8'h11) $display("FAIL nobyp_rdata got=%h exp=11", dbg_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    dec_req = 1'b1; dec_addr = 3'd1; dbg_req = 1'b1; dbg_addr = 3'd6;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        #1;
        n_chk++; if (dec_gnt !== (k < 4)) $display("FAIL starve_dec_gnt r=%0d k=%0d got=%b exp=%b", r, k, dec_gnt, (k < 4)); else n_pass++;
        n_chk++; if (dbg_gnt !== (k == 4)) $display("FAIL starve_dbg_gnt r=%0d k=%0d got=%b exp=%b", r, k, dbg_gnt, (k == 4)); else n_pass++;
        n_chk++; if (stall !== (k == 4)) $display("FAIL starve_stall r=%0d k=%0d got=%b exp=%b", r, k, stall, (k == 4)); else n_pass++;
        n_chk++; if (rf_rdreg !== ((k < 4) ? 3'd1 : 3'd6)) $display("FAIL starve_rdreg r=%0d k=%0d got=%0d", r, k, rf_rdreg); else n_pass++;
        tick();
        n_chk++; if (dec_rvalid !== (k < 4)) $display("FAIL b2b_dec_rvalid r=%0d k=%0d got=%b exp=%b", r, k, dec_rvalid, (k < 4)); else n_pass++;
        n_chk++; if (dbg_rvalid !== (k == 4)) $display("FAIL b2b_dbg_rvalid r=%0d k=%0d got=%b exp=%b", r, k, dbg_rvalid, (k == 4)); else n_pass++;
      end
    end
    n_chk++; if (dec_rdata !== 8'hA1) $display("FAIL starve_dec_rdata got=%h exp=a1", dec_rdata); else n_pass++;
    n_chk++; if (dbg_rdata !== 8'hA6) $display("FAIL starve_dbg_rdata got=%h exp=a6", dbg_rdata); else n_pass++;
    dec_req = 1'b0; dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    dec_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL drop_pre k=%0d got=%b exp=0", k, dbg_gnt); else n_pass++;
      tick();
    end
    dbg_req = 1'b0;
    #1;
    n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL drop_gap_gnt got=%b exp=0", dbg_gnt); else n_pass++;
    tick();
    n_chk++; if (dbg_rvalid !== 1'b0) $display("FAIL drop_gap_rvalid got=%b exp=0", dbg_rvalid); else n_pass++;
    dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL drop_post k=%0d got=%b exp=0", k, dbg_gnt); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (dbg_gnt !== 1'b1) $display("FAIL drop_force_gnt got=%b exp=1", dbg_gnt); else n_pass++;
    n_chk++; if (dec_gnt !== 1'b0) $display("FAIL drop_force_dec got=%b exp=0", dec_gnt); else n_pass++;
    tick();
    dec_req = 1'b0; dbg_req = 1'b0;
    n_chk++; if (dbg_rvalid !== 1'b1) $display("FAIL drop_force_rvalid got=%b exp=1", dbg_rvalid); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    dec_req = 1'b1; dec_addr = 3'd1; dbg_req = 1'b1; dbg_addr = 3'd6;
    tick(); tick();
    #2;
    n_chk++; if (dec_gnt !== 1'b1) $display("FAIL midrst_pre_gnt got=%b exp=1", dec_gnt); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (dec_gnt !== 1'b0) $display("FAIL midrst_gnt got=%b exp=0", dec_gnt); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL midrst_stall got=%b exp=0", stall); else n_pass++;
    tick();
    dec_req = 1'b0; dbg_req = 1'b0; rst = 1'b1;
    #1;
    n_chk++; if (dec_rvalid !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", dec_rvalid); else n_pass++;
    n_chk++; if (dec_rdata !== 8'h00) $display("FAIL midrst_dec_rdata got=%h exp=00", dec_rdata); else n_pass++;
    n_chk++; if (dbg_rdata !== 8'h00) $display("FAIL midrst_dbg_rdata got=%h exp=00", dbg_rdata); else n_pass++;
    tick();
    dec_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (dbg_gnt !== 1'b0) $display("FAIL midrst_cnt k=%0d got=%b exp=0", k, dbg_gnt); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (dbg_gnt !== 1'b1) $display("FAIL midrst_force got=%b exp=1", dbg_gnt); else n_pass++;
    tick();
    dec_req = 1'b0; dbg_req = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 8; i++) rf_mem[i] = 8'hA0 + 8'(i);
    rf_mem[2] = 8'h5A;
    rf_mem[5] = 8'h11;
    test_reset();
    test_dec_read();
    test_bypass();
    test_no_bypass();
    test_starve();
    test_req_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width SHALL match the register file word.
REQ-002 Parameter ADDR_W, default 3, register address width SHALL select one of 8 registers.
REQ-003 Parameter STARVE_MAX, default 4, legal 1..15, SHALL be the debug wait-cycle limit before forced debug grant.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 dec_req  input  1  decode stage read request (level, per cycle).
REQ-007 dec_addr  input  ADDR_W  decode read address.
REQ-008 dec_gnt  output  1  decode granted this cycle.
REQ-009 dec_rvalid  output  1  dec_rdata valid.
REQ-010 dec_rdata  output  DATA_W  decode read data.
REQ-011 dbg_req / dbg_addr / dbg_gnt / dbg_rvalid / dbg_rdata SHALL be the debug-host port, same widths and meanings as the decode port.
REQ-012 wb_en  input  1; wb_addr  input  ADDR_W; wb_data  input  DATA_W  write-back stage write, observed for bypass.
REQ-013 rf_rdreg  output  ADDR_W  address driven to the register file single read port.
REQ-014 rf_rdt  input  DATA_W  combinational read data returned by the register file.
REQ-015 stall  output  1  decode stall request to the pipeline.

Function
REQ-016 At most one of dec_gnt, dbg_gnt SHALL be high in any cycle.
REQ-017 Grants SHALL be combinational from current requests and the starvation counter.
REQ-018 Normal priority: dec_req high SHALL grant decode; else dbg_req high SHALL grant debug.
REQ-019 Starvation counter (4 bits) SHALL increment each cycle dbg_req=1 and dbg_gnt=0, saturating at STARVE_MAX.
REQ-020 Counter SHALL clear to 0 on any cycle with dbg_gnt=1 or dbg_req=0.
REQ-021 When counter==STARVE_MAX and dbg_req=1, debug SHALL be granted regardless of dec_req.
REQ-022 rf_rdreg SHALL equal the granted requester's address; 0 when no grant.
REQ-023 On a grant cycle, read data SHALL be captured at the next rising edge into the granted port's rdata register.
REQ-024 Captured value SHALL be wb_data when wb_en=1 and wb_addr==rf_rdreg, else rf_rdt.
REQ-025 Granted port's rvalid SHALL be high exactly one cycle, the cycle after the grant (latency 1).
REQ-026 rdata SHALL hold its last captured value until the next capture for that port.
REQ-027 stall SHALL equal dec_req AND NOT dec_gnt.
REQ-028 Back-to-back grants to the same port SHALL produce rvalid on consecutive cycles with no bubble.
REQ-029 A request deasserted before grant SHALL leave no pending state; no grant, no rvalid.
REQ-030 Grant/capture state SHALL be the counter plus two rvalid flags and two rdata registers.

Reset
REQ-031 While rst=0, dec_gnt, dbg_gnt, stall SHALL be 0 and rf_rdreg SHALL be 0.
REQ-032 rst=0 SHALL asynchronously clear counter, both rvalid flags and both rdata registers to 0.
REQ-033 An rvalid due in the cycle after reset assertion SHALL be suppressed.
REQ-034 First grant SHALL be possible in the first cycle with rst=1.

Verification
REQ-035 dec_req=1, dec_addr=2, rf_rdt=0x5A, no debug -> dec_gnt=1, rf_rdreg=2, next cycle dec_rvalid=1, dec_rdata=0x5A, stall=0.
REQ-036 dec_req and dbg_req held high, STARVE_MAX=4 -> decode granted 4 cycles, debug granted cycle 5 with stall=1 that cycle, counter=0 after, pattern repeats.
REQ-037 dbg_req=1, dbg_addr=5, wb_en=1, wb_addr=5, wb_data=0x33, rf_rdt=0x11 -> next cycle dbg_rvalid=1, dbg_rdata=0x33.
REQ-038 wb_en=1, wb_addr=4, read of addr 5 -> rdata=rf_rdt, no bypass.
REQ-039 Grant to decode, rst pulsed low before next edge -> dec_rvalid stays 0, dec_rdata=0, counter=0.
REQ-040 dbg_req high 3 cycles under dec_req, drops 1 cycle, returns -> counter restarts from 0; debug granted only after 4 further denied cycles.
